// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the I2C transaction sequencer:
//   - master op mode codes (as driven on m_mode)
//   - NACK stage codes reported on rsp_stage
//   - state enums for the sequencer FSM and the op issuer FSM
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

   localparam logic [1:0] MODE_WRITE = 2'b00;
   localparam logic [1:0] MODE_START = 2'b01;
   localparam logic [1:0] MODE_STOP  = 2'b10;
   localparam logic [1:0] MODE_READ  = 2'b11;

   localparam logic [1:0] STG_ADDR_W = 2'd0;
   localparam logic [1:0] STG_REG    = 2'd1;
   localparam logic [1:0] STG_DATA   = 2'd2;
   localparam logic [1:0] STG_ADDR_R = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_ADDR_W,
      S_REG,
      S_WDATA,
      S_RSTART,
      S_ADDR_R,
      S_RDATA,
      S_STOP,
      S_RESP
   } seq_state_t;

   typedef enum logic [1:0] {
      I_IDLE,
      I_ISSUE,
      I_WAIT
   } iss_state_t;

endpackage

// File: rtl/i2c_op_issuer.sv
// ---------------------------------------------------------------------------
// i2c_op_issuer
// Runs the ISSUE/WAIT handshake for one byte-level master op at a time.
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   i_go              1-cycle request; mode/data captured, only honoured idle
//   i_mode, i_data    requested op mode and tx byte
//   i_m_ready         master can accept an op
//   i_m_done          master op-complete pulse
//   i_m_rx_data       master rx byte (bit0 = ACK after a write op)
//   o_m_enable        1-cycle op pulse to the master
//   o_m_mode          op mode, held stable from capture until the next request
//   o_m_tx_data       op tx byte, held stable likewise
//   o_op_done         op complete (combinational, same cycle as i_m_done)
//   o_op_ack          ACK bit sampled with o_op_done (1 = NACK)
//   o_op_rdata        rx byte sampled with o_op_done
//   o_state           issuer state, for debug
// ---------------------------------------------------------------------------
module i2c_op_issuer
   import i2c_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_go,
   input  logic [1:0] i_mode,
   input  logic [7:0] i_data,
   input  logic       i_m_ready,
   input  logic       i_m_done,
   input  logic [7:0] i_m_rx_data,
   output logic       o_m_enable,
   output logic [1:0] o_m_mode,
   output logic [7:0] o_m_tx_data,
   output logic       o_op_done,
   output logic       o_op_ack,
   output logic [7:0] o_op_rdata,
   output logic [1:0] o_state
);

   iss_state_t r_state;
   logic       r_enable;
   logic [1:0] r_mode;
   logic [7:0] r_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= I_IDLE;
         r_enable <= 1'b0;
         r_mode   <= MODE_WRITE;
         r_data   <= 8'h00;
      end else begin
         r_enable <= 1'b0;
         case (r_state)
            I_IDLE: begin
               if (i_go) begin
                  r_mode  <= i_mode;
                  r_data  <= i_data;
                  r_state <= I_ISSUE;
               end
            end
            I_ISSUE: begin
               if (i_m_ready) begin
                  r_enable <= 1'b1;
                  r_state  <= I_WAIT;
               end
            end
            I_WAIT: begin
               // A done in the enable cycle cannot belong to this op.
               if (i_m_done && !r_enable) r_state <= I_IDLE;
            end
            default: r_state <= I_IDLE;
         endcase
      end
   end

   assign o_m_enable  = r_enable;
   assign o_m_mode    = r_mode;
   assign o_m_tx_data = r_data;
   assign o_op_done   = (r_state == I_WAIT) && i_m_done && !r_enable;
   assign o_op_ack    = i_m_rx_data[0];
   assign o_op_rdata  = i_m_rx_data;
   assign o_state     = r_state;

endmodule

// File: rtl/i2c_txn_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_txn_sequencer
// Turns one register command into a full I2C transaction on a byte-level
// master: write = START, addr+W, reg, N data, STOP; read = START, addr+W,
// reg, repeated START, addr+R, N data, STOP. Every written byte's ACK is
// checked; a NACK goes straight to STOP and is reported on rsp_err/rsp_stage.
// Optional build macro: I2C_SEQ_RETRY_EN -- on NACK, restart the latched
// command up to RETRY_MAX times provided no payload byte has moved yet.
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   cmd_*               command request (valid/ready), fields latched on accept
//   wdata*              write payload stream; wdata_ready pulses with m_enable
//   rdata, rdata_valid  read payload, one pulse per byte, no backpressure
//   rsp_*               end-of-transaction pulse and sticky status
//   m_*                 byte-level master op interface
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both 1; a valid source holds its data stable until that edge.
// ---------------------------------------------------------------------------
module i2c_txn_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int LEN_W     = 4,
   parameter int RETRY_MAX = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_rw,
   input  logic [6:0]       cmd_dev_addr,
   input  logic [7:0]       cmd_reg_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [7:0]       wdata,
   input  logic             wdata_valid,
   output logic             wdata_ready,
   output logic [7:0]       rdata,
   output logic             rdata_valid,
   output logic             rsp_valid,
   output logic             rsp_err,
   output logic [1:0]       rsp_stage,
   output logic [7:0]       m_tx_data,
   output logic [1:0]       m_mode,
   output logic             m_enable,
   input  logic [7:0]       m_rx_data,
   input  logic             m_done,
   input  logic             m_ready
);

`ifdef I2C_SEQ_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif
   localparam int RC_W = $clog2(RETRY_MAX + 2);

   seq_state_t       r_state;
   logic             r_rw;
   logic [6:0]       r_dev;
   logic [7:0]       r_reg;
   logic [LEN_W-1:0] r_cnt;
   logic             r_pending;
   logic             r_go;
   logic [1:0]       r_go_mode;
   logic [7:0]       r_go_data;
   logic             r_nack;
   logic [1:0]       r_stage;
   logic             r_moved;
   logic [RC_W-1:0]  r_retry_cnt;
   logic             r_cmd_ready;
   logic [7:0]       r_rdata;
   logic             r_rdata_valid;
   logic             r_rsp_valid;
   logic             r_rsp_err;
   logic [1:0]       r_rsp_stage;

   logic             w_op_done;
   logic             w_op_ack;
   logic [7:0]       w_op_rdata;
   logic             w_m_enable;
   logic [1:0]       w_iss_state;
   logic             w_op_state;
   logic             w_iss_ok;
   logic [1:0]       w_iss_mode;
   logic [7:0]       w_iss_data;
   logic             w_can_retry;

   // Op requested by the current state; WDATA waits for a payload byte.
   always_comb begin
      w_op_state = 1'b1;
      w_iss_ok   = 1'b1;
      w_iss_mode = MODE_WRITE;
      w_iss_data = 8'h00;
      case (r_state)
         S_START, S_RSTART: w_iss_mode = MODE_START;
         S_ADDR_W:          w_iss_data = {r_dev, 1'b0};
         S_REG:             w_iss_data = r_reg;
         S_WDATA: begin
            w_iss_data = wdata;
            w_iss_ok   = wdata_valid;
         end
         S_ADDR_R:          w_iss_data = {r_dev, 1'b1};
         S_RDATA:           w_iss_mode = MODE_READ;
         S_STOP:            w_iss_mode = MODE_STOP;
         default:           w_op_state = 1'b0;
      endcase
   end

   assign w_can_retry = RETRY_EN && r_nack && !r_moved && (int'(r_retry_cnt) < RETRY_MAX);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_rw          <= 1'b0;
         r_dev         <= 7'h00;
         r_reg         <= 8'h00;
         r_cnt         <= '0;
         r_pending     <= 1'b0;
         r_go          <= 1'b0;
         r_go_mode     <= MODE_WRITE;
         r_go_data     <= 8'h00;
         r_nack        <= 1'b0;
         r_stage       <= STG_ADDR_W;
         r_moved       <= 1'b0;
         r_retry_cnt   <= '0;
         r_cmd_ready   <= 1'b1;
         r_rdata       <= 8'h00;
         r_rdata_valid <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_stage   <= 2'd0;
      end else begin
         r_go          <= 1'b0;
         r_rdata_valid <= 1'b0;
         r_rsp_valid   <= 1'b0;

         if (w_op_state && !r_pending && w_iss_ok) begin
            r_go      <= 1'b1;
            r_go_mode <= w_iss_mode;
            r_go_data <= w_iss_data;
            r_pending <= 1'b1;
            if (r_state == S_WDATA) r_moved <= 1'b1;
         end

         if (w_op_state && r_pending && w_op_done) begin
            r_pending <= 1'b0;
            case (r_state)
               S_START:  r_state <= S_ADDR_W;
               S_ADDR_W: begin
                  if (w_op_ack) begin
                     r_nack <= 1'b1; r_stage <= STG_ADDR_W; r_state <= S_STOP;
                  end else begin
                     r_state <= S_REG;
                  end
               end
               S_REG: begin
                  if (w_op_ack) begin
                     r_nack <= 1'b1; r_stage <= STG_REG; r_state <= S_STOP;
                  end else if (r_cnt == '0) begin
                     r_state <= S_STOP;
                  end else begin
                     r_state <= r_rw ? S_RSTART : S_WDATA;
                  end
               end
               S_WDATA: begin
                  r_cnt <= r_cnt - 1'b1;
                  if (w_op_ack) begin
                     r_nack <= 1'b1; r_stage <= STG_DATA; r_state <= S_STOP;
                  end else if (r_cnt == 1) begin
                     r_state <= S_STOP;
                  end
               end
               S_RSTART: r_state <= S_ADDR_R;
               S_ADDR_R: begin
                  if (w_op_ack) begin
                     r_nack <= 1'b1; r_stage <= STG_ADDR_R; r_state <= S_STOP;
                  end else begin
                     r_state <= S_RDATA;
                  end
               end
               S_RDATA: begin
                  r_rdata       <= w_op_rdata;
                  r_rdata_valid <= 1'b1;
                  r_moved       <= 1'b1;
                  r_cnt         <= r_cnt - 1'b1;
                  if (r_cnt == 1) r_state <= S_STOP;
               end
               S_STOP: begin
                  if (w_can_retry) begin
                     r_retry_cnt <= r_retry_cnt + 1'b1;
                     r_nack      <= 1'b0;
                     r_state     <= S_START;
                  end else begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= r_nack;
                     r_rsp_stage <= r_nack ? r_stage : 2'd0;
                     r_state     <= S_RESP;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end

         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_rw        <= cmd_rw;
                  r_dev       <= cmd_dev_addr;
                  r_reg       <= cmd_reg_addr;
                  r_cnt       <= cmd_len;
                  r_cmd_ready <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_stage <= 2'd0;
                  r_nack      <= 1'b0;
                  r_moved     <= 1'b0;
                  r_retry_cnt <= '0;
                  r_state     <= S_START;
               end
            end
            S_RESP: begin
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: ;
         endcase
      end
   end

   i2c_op_issuer u_issuer (
      .clk         (clk),
      .reset       (reset),
      .i_go        (r_go),
      .i_mode      (r_go_mode),
      .i_data      (r_go_data),
      .i_m_ready   (m_ready),
      .i_m_done    (m_done),
      .i_m_rx_data (m_rx_data),
      .o_m_enable  (w_m_enable),
      .o_m_mode    (m_mode),
      .o_m_tx_data (m_tx_data),
      .o_op_done   (w_op_done),
      .o_op_ack    (w_op_ack),
      .o_op_rdata  (w_op_rdata),
      .o_state     (w_iss_state)
   );

   // The payload byte is consumed in the cycle its write op is launched.
   assign wdata_ready = w_m_enable && (r_state == S_WDATA);
   assign m_enable    = w_m_enable;
   assign cmd_ready   = r_cmd_ready;
   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_err     = r_rsp_err;
   assign rsp_stage   = r_rsp_stage;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
module tb_i2c_txn_sequencer;
   import i2c_seq_pkg::*;

   localparam logic [9:0] OP_ST = 10'h100;
   localparam logic [9:0] OP_SP = 10'h200;
   localparam logic [9:0] OP_RD = 10'h300;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_rw = 1'b0;
   logic [6:0] cmd_dev_addr = 7'h00;
   logic [7:0] cmd_reg_addr = 8'h00;
   logic [3:0] cmd_len = 4'h0;
   logic [7:0] wdata = 8'h00;
   logic       wdata_valid = 1'b0;
   logic       wdata_ready;
   logic [7:0] rdata;
   logic       rdata_valid;
   logic       rsp_valid;
   logic       rsp_err;
   logic [1:0] rsp_stage;
   logic [7:0] m_tx_data;
   logic [1:0] m_mode;
   logic       m_enable;
   logic [7:0] m_rx_data = 8'h00;
   logic       m_done = 1'b0;
   logic       m_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   i2c_txn_sequencer #(.LEN_W(4), .RETRY_MAX(3)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_len(cmd_len),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .rdata(rdata), .rdata_valid(rdata_valid),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_stage(rsp_stage),
      .m_tx_data(m_tx_data), .m_mode(m_mode), .m_enable(m_enable),
      .m_rx_data(m_rx_data), .m_done(m_done), .m_ready(m_ready)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- byte-level master + slave model ----------------
   // Slave at 0x50 only; optional forced NACK at op index nack_idx.
   logic [9:0] op_log[$];
   logic [7:0] rd_src[$];
   int         nack_idx = -1;
   logic       m_busy = 1'b0;
   int         m_dly = 0;
   logic [1:0] m_prev_mode = MODE_STOP;

   always @(posedge clk) begin
      int idx;
      m_done <= 1'b0;
      if (!reset) begin
         m_busy  <= 1'b0;
         m_ready <= 1'b1;
      end else if (m_busy) begin
         if (m_enable) begin
            errors++;
            $display("FAIL enable_while_busy got m_enable=1 exp 0");
         end
         if (m_dly == 0) begin
            m_done  <= 1'b1;
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
         end else begin
            m_dly <= m_dly - 1;
         end
      end else if (m_enable) begin
         idx = op_log.size();
         op_log.push_back({m_mode, (m_mode == MODE_WRITE) ? m_tx_data : 8'h00});
         m_busy      <= 1'b1;
         m_ready     <= 1'b0;
         m_dly       <= 2;
         m_prev_mode <= m_mode;
         if (m_mode == MODE_READ)
            m_rx_data <= (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
         else if (m_mode == MODE_WRITE)
            m_rx_data <= {7'h00, ((m_prev_mode == MODE_START) && (m_tx_data[7:1] != 7'h50)) || (idx == nack_idx)};
         else
            m_rx_data <= 8'h00;
      end
   end

   // ---------------- output monitor (opposite edge) ----------------
   int         wr_cnt = 0;
   logic [7:0] rd_got[$];
   logic       rsp_seen = 1'b0;
   logic       rsp_err_q = 1'b0;
   logic [1:0] rsp_stage_q = 2'd0;

   always @(negedge clk) begin
      if (wdata_ready) wr_cnt++;
      if (rdata_valid) rd_got.push_back(rdata);
      if (rsp_valid) begin
         rsp_seen    = 1'b1;
         rsp_err_q   = rsp_err;
         rsp_stage_q = rsp_stage;
      end
   end

   // ---------------- driver tasks ----------------
   logic [7:0] wdata_q[$];
   logic [9:0] exp_q[$];
   logic       txn_timeout;
   int         ops_at_hold;

   task automatic clear_mon();
      op_log.delete();
      rd_got.delete();
      wr_cnt   = 0;
      rsp_seen = 1'b0;
   endtask

   task automatic drive_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      cmd_valid = 1'b1; cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = rg; cmd_len = len;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_txn(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len, input int hold);
      int   cyc = 0;
      logic pop;
      clear_mon();
      drive_cmd(rw, dev, rg, len);
      ops_at_hold = -1;
      while (!rsp_seen && cyc < 5000) begin
         if (cyc == hold) ops_at_hold = op_log.size();
         wdata_valid = (wdata_q.size() > 0) && (cyc >= hold);
         wdata = (wdata_q.size() > 0) ? wdata_q[0] : 8'h00;
         @(negedge clk);
         pop = wdata_ready;
         @(posedge clk); #1;
         if (pop) void'(wdata_q.pop_front());
         cyc++;
      end
      wdata_valid = 1'b0;
      txn_timeout = !rsp_seen;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
      checks++; if (m_enable !== 1'b0) begin errors++; $display("FAIL reset_m_enable got %b exp 0", m_enable); end
      checks++; if (m_mode !== 2'b00) begin errors++; $display("FAIL reset_m_mode got %b exp 00", m_mode); end
      checks++; if (m_tx_data !== 8'h00) begin errors++; $display("FAIL reset_m_tx_data got %h exp 00", m_tx_data); end
      checks++; if (wdata_ready !== 1'b0) begin errors++; $display("FAIL reset_wdata_ready got %b exp 0", wdata_ready); end
      checks++; if (rdata_valid !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %b/%h exp 0/00", rdata_valid, rdata); end
      checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_stage !== 2'd0) begin errors++; $display("FAIL reset_rsp got %b/%b/%0d exp 0/0/0", rsp_valid, rsp_err, rsp_stage); end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      wdata_q = '{8'hA5, 8'h3C};
      exp_q   = '{OP_ST, 10'h0A0, 10'h010, 10'h0A5, 10'h03C, OP_SP};
      run_txn(1'b0, 7'h50, 8'h10, 4'd2, 0);
      checks++; if (txn_timeout) begin errors++; $display("FAIL write_done got timeout exp rsp_valid"); end
      checks++; if (op_log.size() !== exp_q.size()) begin errors++; $display("FAIL write_op_count got %0d exp %0d", op_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         checks++; if (op_log[i] !== exp_q[i]) begin errors++; $display("FAIL write_op[%0d] got %h exp %h", i, op_log[i], exp_q[i]); end
      end
      checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL write_wdata_ready got %0d exp 2", wr_cnt); end
      checks++; if (rsp_err_q !== 1'b0) begin errors++; $display("FAIL write_rsp_err got %b exp 0", rsp_err_q); end
   endtask

   task automatic test_read();
      rd_src = '{8'h11, 8'h22, 8'h33};
      exp_q  = '{OP_ST, 10'h0A0, 10'h020, OP_ST, 10'h0A1, OP_RD, OP_RD, OP_RD, OP_SP};
      run_txn(1'b1, 7'h50, 8'h20, 4'd3, 0);
      checks++; if (txn_timeout) begin errors++; $display("FAIL read_done got timeout exp rsp_valid"); end
      checks++; if (op_log.size() !== exp_q.size()) begin errors++; $display("FAIL read_op_count got %0d exp %0d", op_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         checks++; if (op_log[i] !== exp_q[i]) begin errors++; $display("FAIL read_op[%0d] got %h exp %h", i, op_log[i], exp_q[i]); end
      end
      checks++; if (rd_got.size() !== 3) begin errors++; $display("FAIL read_rdata_count got %0d exp 3", rd_got.size()); end
      if (rd_got.size() == 3) begin
         checks++; if (rd_got[0] !== 8'h11 || rd_got[1] !== 8'h22 || rd_got[2] !== 8'h33) begin
            errors++; $display("FAIL read_rdata got %h %h %h exp 11 22 33", rd_got[0], rd_got[1], rd_got[2]);
         end
      end
      checks++; if (rsp_err_q !== 1'b0) begin errors++; $display("FAIL read_rsp_err got %b exp 0", rsp_err_q); end
   endtask

   task automatic test_nack_addr();
      int attempts;
`ifdef I2C_SEQ_RETRY_EN
      attempts = 4;
`else
      attempts = 1;
`endif
      exp_q.delete();
      for (int a = 0; a < attempts; a++) begin
         exp_q.push_back(OP_ST); exp_q.push_back(10'h078); exp_q.push_back(OP_SP);
      end
      wdata_q = '{8'h99};
      run_txn(1'b0, 7'h3C, 8'h10, 4'd1, 0);
      checks++; if (txn_timeout) begin errors++; $display("FAIL nack_addr_done got timeout exp rsp_valid"); end
      checks++; if (op_log.size() !== exp_q.size()) begin errors++; $display("FAIL nack_addr_op_count got %0d exp %0d", op_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         checks++; if (op_log[i] !== exp_q[i]) begin errors++; $display("FAIL nack_addr_op[%0d] got %h exp %h", i, op_log[i], exp_q[i]); end
      end
      checks++; if (rsp_err_q !== 1'b1 || rsp_stage_q !== STG_ADDR_W) begin errors++; $display("FAIL nack_addr_rsp got err=%b stage=%0d exp 1/0", rsp_err_q, rsp_stage_q); end
      checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL nack_addr_wdata_ready got %0d exp 0", wr_cnt); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (rsp_err !== 1'b1 || rsp_stage !== STG_ADDR_W) begin errors++; $display("FAIL nack_addr_sticky got err=%b stage=%0d exp 1/0", rsp_err, rsp_stage); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL nack_addr_idle got cmd_ready=%b exp 1", cmd_ready); end
      wdata_q.delete();
   endtask

   task automatic test_nack_data();
      nack_idx = 3;
      wdata_q  = '{8'hA5, 8'h3C};
      exp_q    = '{OP_ST, 10'h0A0, 10'h010, 10'h0A5, OP_SP};
      run_txn(1'b0, 7'h50, 8'h10, 4'd2, 0);
      nack_idx = -1;
      checks++; if (txn_timeout) begin errors++; $display("FAIL nack_data_done got timeout exp rsp_valid"); end
      checks++; if (op_log.size() !== exp_q.size()) begin errors++; $display("FAIL nack_data_op_count got %0d exp %0d", op_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         checks++; if (op_log[i] !== exp_q[i]) begin errors++; $display("FAIL nack_data_op[%0d] got %h exp %h", i, op_log[i], exp_q[i]); end
      end
      checks++; if (rsp_err_q !== 1'b1 || rsp_stage_q !== STG_DATA) begin errors++; $display("FAIL nack_data_rsp got err=%b stage=%0d exp 1/2", rsp_err_q, rsp_stage_q); end
      checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL nack_data_wdata_ready got %0d exp 1", wr_cnt); end
      wdata_q.delete();
   endtask

   task automatic test_len0();
      exp_q = '{OP_ST, 10'h0A0, 10'h005, OP_SP};
      run_txn(1'b0, 7'h50, 8'h05, 4'd0, 0);
      checks++; if (txn_timeout) begin errors++; $display("FAIL len0_wr_done got timeout exp rsp_valid"); end
      checks++; if (op_log.size() !== exp_q.size()) begin errors++; $display("FAIL len0_wr_op_count got %0d exp %0d", op_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         checks++; if (op_log[i] !== exp_q[i]) begin errors++; $display("FAIL len0_wr_op[%0d] got %h exp %h", i, op_log[i], exp_q[i]); end
      end
      checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL len0_wr_wdata_ready got %0d exp 0", wr_cnt); end
      checks++; if (rsp_err_q !== 1'b0) begin errors++; $display("FAIL len0_wr_rsp_err got %b exp 0", rsp_err_q); end
      run_txn(1'b1, 7'h50, 8'h05, 4'd0, 0);
      checks++; if (op_log.size() !== exp_q.size()) begin errors++; $display("FAIL len0_rd_op_count got %0d exp %0d", op_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         checks++; if (op_log[i] !== exp_q[i]) begin errors++; $display("FAIL len0_rd_op[%0d] got %h exp %h", i, op_log[i], exp_q[i]); end
      end
      checks++; if (rd_got.size() !== 0) begin errors++; $display("FAIL len0_rd_rdata_count got %0d exp 0", rd_got.size()); end
   endtask

   task automatic test_wdata_stall();
      wdata_q = '{8'h5A};
      exp_q   = '{OP_ST, 10'h0A0, 10'h030, 10'h05A, OP_SP};
      run_txn(1'b0, 7'h50, 8'h30, 4'd1, 1000);
      checks++; if (ops_at_hold !== 3) begin errors++; $display("FAIL stall_ops_before_valid got %0d exp 3", ops_at_hold); end
      checks++; if (txn_timeout) begin errors++; $display("FAIL stall_done got timeout exp rsp_valid"); end
      checks++; if (op_log.size() !== exp_q.size()) begin errors++; $display("FAIL stall_op_count got %0d exp %0d", op_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         checks++; if (op_log[i] !== exp_q[i]) begin errors++; $display("FAIL stall_op[%0d] got %h exp %h", i, op_log[i], exp_q[i]); end
      end
      checks++; if (wr_cnt !== 1 || rsp_err_q !== 1'b0) begin errors++; $display("FAIL stall_result got wr=%0d err=%b exp 1/0", wr_cnt, rsp_err_q); end
   endtask

   task automatic test_reset_mid_read();
      int n = 0;
      rd_src = '{8'h11, 8'h22, 8'h33};
      clear_mon();
      drive_cmd(1'b1, 7'h50, 8'h20, 4'd3);
      while (rd_got.size() == 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (rd_got.size() == 0) begin errors++; $display("FAIL midrst_first_byte got none exp rdata_valid"); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready got %b exp 1", cmd_ready); end
      checks++; if (m_enable !== 1'b0) begin errors++; $display("FAIL midrst_m_enable got %b exp 0", m_enable); end
      checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL midrst_rdata_valid got %b exp 0", rdata_valid); end
      reset = 1'b1;
      rd_src.delete();
      exp_q = '{OP_ST, 10'h0A0, 10'h005, OP_SP};
      run_txn(1'b0, 7'h50, 8'h05, 4'd0, 0);
      checks++; if (txn_timeout) begin errors++; $display("FAIL midrst_after_done got timeout exp rsp_valid"); end
      checks++; if (op_log.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_after_op_count got %0d exp %0d", op_log.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < op_log.size(); i++) begin
         checks++; if (op_log[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_after_op[%0d] got %h exp %h", i, op_log[i], exp_q[i]); end
      end
      checks++; if (rsp_err_q !== 1'b0) begin errors++; $display("FAIL midrst_after_rsp_err got %b exp 0", rsp_err_q); end
   endtask

   // ---------------- sequence + final report ----------------
   initial begin
      test_reset();
      test_write();
      test_read();
      test_nack_addr();
      test_len0();
      test_nack_data();
      test_wdata_stall();
      test_reset_mid_read();
      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
